// File: rtl/demux_1x8_reg_n_pkg.sv
// Shared constants and FSM encoding for the registered 1-to-8 demultiplexer.
package demux_1x8_reg_n_pkg;

  localparam int SLOT_COUNT = 8;
  localparam int PTR_W      = 3;

  // Slots idle at all ones; replicate this bit to the slot width.
  localparam logic IDLE_BIT = 1'b1;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    FULL    = 2'b10
  } state_t;

endpackage

// File: rtl/demux_1x8_reg_n_if.sv
// Write-side bus of the demux: input word stream plus parallel slot and status outputs.
interface demux_1x8_reg_n_if #(parameter int BITS = 4);

  logic            write_en;
  logic            addr_mode;
  logic [2:0]      SEL;
  logic [BITS-1:0] D_IN;
  logic [BITS-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [2:0]      ptr;
  logic            full;
  logic            done;
  logic            overflow;

  modport master (
    output write_en, addr_mode, SEL, D_IN,
    input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, ptr, full, done, overflow
  );

  modport slave (
    input  write_en, addr_mode, SEL, D_IN,
    output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, ptr, full, done, overflow
  );

endinterface

// File: rtl/demux_1x8_reg_n_counter.sv
// Modulo-8 auto-fill pointer with synchronous reset/clear, enable and terminal count.
module counter_mod8_en
  import demux_1x8_reg_n_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [PTR_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  assign tc = (count == PTR_W'(SLOT_COUNT - 1));

endmodule

// File: rtl/demux_1x8_reg_n.sv
// Registered 1-to-8 demux: stores words into eight slots by auto pointer or explicit SEL.
// state   | meaning
// EMPTY   | no auto writes since reset/clear, ptr = 0
// FILLING | 1..7 slots auto-written, ptr = next slot
// FULL    | all eight slots auto-written; auto writes rejected until clear/reset
module demux_1x8_reg_n
  import demux_1x8_reg_n_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  demux_1x8_reg_n_if.slave bus
);

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q;
  logic                   ptr_tc;
  logic                   auto_wr, auto_accept;
  logic [PTR_W-1:0]       wr_addr;
  logic [SLOT_COUNT-1:0]  slot_we;
  logic                   done_d, ovf_d;
  logic                   done_q, ovf_q;
  logic [BITS-1:0]        slot_q [SLOT_COUNT];

  assign auto_wr     = bus.write_en && !bus.addr_mode && !clear;
  assign auto_accept = auto_wr && (state_q != FULL);

  counter_mod8_en u_ptr (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .en    (auto_accept),
    .count (ptr_q),
    .tc    (ptr_tc)
  );

  always_ff @(posedge clock) begin
    if (reset || clear)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (auto_accept) state_d = FILLING;
      FILLING: if (auto_accept && ptr_tc) state_d = FULL;
      FULL:    state_d = FULL;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    wr_addr = bus.addr_mode ? bus.SEL : ptr_q;
    done_d  = auto_accept && ptr_tc;
    ovf_d   = auto_wr && (state_q == FULL);
    slot_we = '0;
    if (bus.write_en && !clear && (bus.addr_mode || state_q != FULL))
      slot_we[wr_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar i = 0; i < SLOT_COUNT; i++) begin : g_slot
    always_ff @(posedge clock) begin
      if (reset || clear)
        slot_q[i] <= {BITS{IDLE_BIT}};
      else if (slot_we[i])
        slot_q[i] <= bus.D_IN;
    end
  end

  assign bus.Q0       = slot_q[0];
  assign bus.Q1       = slot_q[1];
  assign bus.Q2       = slot_q[2];
  assign bus.Q3       = slot_q[3];
  assign bus.Q4       = slot_q[4];
  assign bus.Q5       = slot_q[5];
  assign bus.Q6       = slot_q[6];
  assign bus.Q7       = slot_q[7];
  assign bus.ptr      = ptr_q;
  assign bus.full     = (state_q == FULL);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_demux_1x8_reg_n.sv
// Bench for demux_1x8_reg_n: directed test-plan steps then random traffic against a slot-array model.
module tb_demux_1x8_reg_n;

  localparam int BITS = 4;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  demux_1x8_reg_n_if #(.BITS(BITS)) bus ();

  demux_1x8_reg_n #(.BITS(BITS)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [BITS-1:0] m_slot [8];
  int              m_ptr;
  bit              m_full, m_done, m_ovf;

  function automatic logic [BITS-1:0] get_q(input int i);
    case (i)
      0: return bus.Q0;
      1: return bus.Q1;
      2: return bus.Q2;
      3: return bus.Q3;
      4: return bus.Q4;
      5: return bus.Q5;
      6: return bus.Q6;
      default: return bus.Q7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit clr, input bit we, input bit am,
                            input int sel, input logic [BITS-1:0] din);
    if (rst || clr) begin
      for (int i = 0; i < 8; i++) m_slot[i] = {BITS{1'b1}};
      m_ptr = 0; m_full = 0; m_done = 0; m_ovf = 0;
    end else begin
      m_done = 0; m_ovf = 0;
      if (we) begin
        if (am) m_slot[sel] = din;
        else if (m_full) m_ovf = 1;
        else begin
          m_slot[m_ptr] = din;
          if (m_ptr == 7) begin m_full = 1; m_done = 1; end
          m_ptr = (m_ptr + 1) % 8;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) chk($sformatf("Q%0d", i), 32'(get_q(i)), 32'(m_slot[i]));
    chk("ptr", 32'(bus.ptr), 32'(m_ptr));
    chk("full", 32'(bus.full), 32'(m_full));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input bit rst, input bit clr, input bit we, input bit am,
                     input int sel, input logic [BITS-1:0] din);
    @(negedge clock);
    reset = rst; clear = clr;
    bus.write_en = we; bus.addr_mode = am; bus.SEL = 3'(sel); bus.D_IN = din;
    @(posedge clock);
    model_edge(rst, clr, we, am, sel, din);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    bus.write_en = 1'b0; bus.addr_mode = 1'b0; bus.SEL = 3'd0; bus.D_IN = '0;
    for (int i = 0; i < 8; i++) m_slot[i] = 'x;
    m_ptr = 0; m_full = 0; m_done = 0; m_ovf = 0;

    // reset then idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_q5", 32'(bus.Q5), 32'hF);

    // eight auto writes 1..8
    for (int n = 0; n < 8; n++) cyc(0, 0, 1, 0, 0, 4'(n + 1));
    chk("fill_q7", 32'(bus.Q7), 32'h8);
    chk("fill_done", 32'(bus.done), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("done_one_cycle", 32'(bus.done), 32'h0);

    // overflow in FULL, then explicit write
    cyc(0, 0, 1, 0, 0, 4'hA);
    chk("ovf_pulse", 32'(bus.overflow), 32'h1);
    cyc(0, 0, 1, 1, 3, 4'h5);
    chk("explicit_q3", 32'(bus.Q3), 32'h5);
    chk("full_held", 32'(bus.full), 32'h1);

    // mixed auto / explicit from empty
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 4'h1);
    cyc(0, 0, 1, 0, 0, 4'h2);
    cyc(0, 0, 1, 1, 6, 4'hC);
    cyc(0, 0, 1, 0, 0, 4'h3);
    chk("mix_q2", 32'(bus.Q2), 32'h3);
    chk("mix_q6", 32'(bus.Q6), 32'hC);
    chk("mix_ptr", 32'(bus.ptr), 32'h3);

    // clear with simultaneous write after three auto writes
    cyc(0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) cyc(0, 0, 1, 0, 0, 4'(n + 7));
    cyc(0, 1, 1, 0, 0, 4'h9);
    chk("clr_q0", 32'(bus.Q0), 32'hF);
    chk("clr_ptr", 32'(bus.ptr), 32'h0);

    // reset during an overflow cycle
    for (int n = 0; n < 8; n++) cyc(0, 0, 1, 0, 0, 4'(n));
    cyc(0, 0, 1, 0, 0, 4'hA);
    cyc(1, 0, 1, 0, 0, 4'hB);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      automatic bit rst = ($urandom_range(0, 99) < 2);
      automatic bit clr = ($urandom_range(0, 99) < 4);
      automatic bit we  = ($urandom_range(0, 99) < 80);
      automatic bit am  = ($urandom_range(0, 99) < 30);
      cyc(rst, clr, we, am, int'($urandom_range(0, 7)), BITS'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1x8_reg_n.md
# demux_1x8_reg_n

Registered 1-to-8 demultiplexer: the write-side counterpart of the 8-input word selector. It accepts a stream of BITS-wide words on one input and stores each word into one of eight slot registers, either by an auto-incrementing pointer or by an explicit 3-bit slot select. All eight slots are presented in parallel to downstream selection logic, with fill status, completion and overflow flags.

## Interface

Parameters:
- BITS, default 4: width of each data word and of each slot register.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear of slots, pointer and flags.
- write_en  input  1  one-cycle write strobe; one word accepted per asserted cycle.
- addr_mode  input  1  0 = auto-increment pointer, 1 = explicit slot via SEL.
- SEL  input  3  target slot when addr_mode = 1; ignored otherwise.
- D_IN  input  BITS  data word to store.
- Q0..Q7  output  BITS each  slot registers, Qn = slot n.
- ptr  output  3  next slot for auto mode.
- full  output  1  all eight slots written in auto mode since the last reset or clear.
- done  output  1  one-cycle pulse on the cycle after slot 7 is written in auto mode.
- overflow  output  1  one-cycle pulse when an auto-mode write is rejected because full = 1.

## Operation

- Reset values (reset = 1): Q0..Q7 = {BITS{1'b1}}, which is the idle pattern of the selector; ptr = 0; full = 0; done = 0; overflow = 0.
- Priority, highest first: reset, clear, write_en. clear has the same effect as reset on every output. A write in the same cycle as clear is discarded.
- FSM states (registered, 2 bits):
  - EMPTY: ptr = 0, full = 0.
  - FILLING: 1 ≤ ptr ≤ 7, full = 0.
  - FULL: full = 1, ptr = 0.
- Auto write (write_en = 1, addr_mode = 0):
  - In EMPTY or FILLING: Q[ptr] ← D_IN and ptr ← ptr + 1 modulo 8.
  - Writing slot 0 from EMPTY moves to FILLING.
  - Writing slot 7 moves to FULL, wraps ptr to 0, sets full and pulses done.
  - In FULL: no slot changes, ptr is held and overflow pulses.
- Explicit write (write_en = 1, addr_mode = 1): Q[SEL] ← D_IN in every state. ptr, full and the FSM state are unchanged. done and overflow are not pulsed.
- Leaving FULL requires clear or reset.
- With write_en = 0, all state holds. done and overflow return to 0.
- Outputs are registered only; no combinational path from inputs to outputs.

## Timing

- Write latency is 1 cycle: D_IN sampled at edge k appears on Qn after edge k.
- ptr, full, done and overflow update on the same edge as the slot write.
- done is high for exactly one cycle, after the edge that wrote slot 7. The same holds for overflow after the rejected edge.
- Back-to-back writes on every cycle are supported. Eight consecutive auto writes from EMPTY produce full = 1 after the 8th edge.
- Reset or clear mid-fill takes effect at the next edge. The partial fill is discarded and all slots return to all-ones.
- SEL and addr_mode are sampled only when write_en = 1.

## Structure

- The shared package/include holds:
  - the slot count constant (8);
  - the pointer width constant (3);
  - the FSM state encodings EMPTY = 2'b00, FILLING = 2'b01, FULL = 2'b10;
  - the idle slot value macro (all ones).
- One natural sub-module, counter_mod8_en: a 3-bit modulo-8 counter with synchronous reset, clear and enable, plus a terminal-count output used to detect the slot 7 write.
- The slot bank is eight BITS-wide registers with per-slot write enables decoded from the effective address (ptr or SEL).

## Test plan

- Reset with BITS = 4, then no writes → Q0..Q7 = 4'hF, ptr = 0, full = 0, done = 0, overflow = 0.
- Auto writes of D_IN = 1..8 on consecutive cycles → Qn = n+1; done high for exactly the one cycle after the 8th write; full = 1; ptr = 0.
- From FULL, auto write of 4'hA → slots unchanged, overflow pulses one cycle; then explicit write with SEL = 3, D_IN = 4'h5 → Q3 = 5, full stays 1.
- Auto writes of 4'h1, 4'h2, then explicit write with SEL = 6, D_IN = 4'hC, then auto write of 4'h3 → Q0 = 1, Q1 = 2, Q2 = 3, Q6 = C, ptr = 3, full = 0.
- After three auto writes, assert clear together with write_en → all slots 4'hF, ptr = 0, full = 0, incoming word discarded.
- Assert reset during a FULL-state overflow cycle → next cycle all outputs at reset values, overflow = 0.
